dram_cmd_scheduler: RTL and testbench
=====================================

// Module: dram_cmd_scheduler
// PURPOSE
//  Scheduler end of the bank-request/grant handshake: accepts act/rd/wr/pre/ref requests from NUM_BANKS
//  bank controllers, grants at most one per cycle under inter-bank timing (tRRD, tCCD, tWTR, tRTW),
//  and drives the registered DFI command bus (cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt) to the PHY.
//  Per-bank timing (tRCD/tRP/tRAS/tRFC/tRTP/tWTP) is enforced by the bank controllers, not here.
// PARAMETERS
//  NUM_BANKS   4   bank controllers served; power of 2
//  BA_WIDTH    2   DFI bank-address width, = log2(NUM_BANKS)
//  RA_WIDTH    14  row-address width per bank
//  CA_WIDTH    10  column-address width per bank
//  ADDR_WIDTH  14  DFI address width; >= RA_WIDTH, >= 11 (A10 used)
//  CS_WIDTH    1   DFI chip-select width
//  T_WIDTH     4   width of each timing input
// PORTS
//  clk        in   1                     clock
//  rst_n      in   1                     asynchronous, active-low reset
//  act_req    in   NUM_BANKS             per-bank ACT request (level, held until grant)
//  rd_req     in   NUM_BANKS             per-bank RD request
//  wr_req     in   NUM_BANKS             per-bank WR request
//  pre_req    in   NUM_BANKS             per-bank PRE request
//  ref_req    in   NUM_BANKS             per-bank refresh-ready (bank idle, wants REF)
//  ra         in   NUM_BANKS*RA_WIDTH    per-bank row address, bank b at [b*RA_WIDTH +: RA_WIDTH]
//  ca         in   NUM_BANKS*CA_WIDTH    per-bank column address, same packing
//  act_gnt    out  NUM_BANKS             one-hot ACT grant
//  rd_gnt     out  NUM_BANKS             one-hot RD grant
//  wr_gnt     out  NUM_BANKS             one-hot WR grant
//  pre_gnt    out  NUM_BANKS             one-hot PRE grant
//  ref_gnt    out  NUM_BANKS             REF grant (all bits together)
//  t_rrd, t_ccd, t_wtr, t_rtw  in  T_WIDTH each   min cycles ACT->ACT, CAS->CAS, WR->RD, RD->WR; quasi-static
//  dfi_cke    out  1                     DFI clock enable
//  dfi_cs_n   out  CS_WIDTH              DFI chip select
//  dfi_ras_n  out  1                     DFI RAS
//  dfi_cas_n  out  1                     DFI CAS
//  dfi_we_n   out  1                     DFI WE
//  dfi_ba     out  BA_WIDTH              DFI bank address
//  dfi_addr   out  ADDR_WIDTH            DFI address
//  dfi_odt    out  1                     DFI on-die termination
// BEHAVIOUR
//  - Grants are combinational from the current-cycle reqs, counters and RR pointer; at most one grant bit set per cycle.
//    Requester deasserts the granted req the next cycle.
//  - DFI outputs are registered: a grant in cycle N puts the command on DFI in cycle N+1, for exactly one cycle.
//  - Class priority: REF (only when &ref_req) > column (RD/WR) > ACT > PRE.
//    Within a class, round-robin from rr_ptr; after any grant to bank b, rr_ptr <= (b+1) mod NUM_BANKS.
//  - Eligibility:
//    - RD needs ccd_cnt==0 && wtr_cnt==0.
//    - WR needs ccd_cnt==0 && rtw_cnt==0.
//    - ACT needs rrd_cnt==0.
//    - PRE and REF are always eligible.
//    An ineligible column request does not block ACT/PRE from granting.
//  - Counters (T_WIDTH, saturate at 0), loaded on grant with max(t-1,0), else decrement if nonzero:
//    - ACT loads rrd_cnt.
//    - RD/WR load ccd_cnt.
//    - WR loads wtr_cnt.
//    - RD loads rtw_cnt.
//    Net effect: next same-class grant at earliest N+t; t=0 or 1 means back-to-back.
//  - Encodings (cs_n=0, ba=bank): ACT r/c/w=0/1/1, addr=ra; RD 1/0/1, addr=ca with A10=0; WR 1/0/0, addr=ca with A10=0;
//    PRE 0/1/0 with A10=0 (single bank); REF 0/0/1 with ba=0, addr=0.
//  - Idle cycle: deselect, i.e. cs_n all 1, ras_n/cas_n/we_n=1, ba=0, addr=0.
//  - dfi_odt=1 in the cycle a WR is driven, else 0.
//  - Reset values: cs_n all 1, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=0, cke=0, all counters 0, rr_ptr=0.
//    cke goes to 1 on the first clock after reset release and stays 1.
//  - Grant outputs are 0 while rst_n=0. Asserting rst_n mid-command forces the deselect state immediately.
//  - A bank asserting more than one of act/rd/wr/pre in the same cycle is illegal (bench assertion).
//    The design then resolves within that bank as rd > wr > act > pre.
//  - Partial ref_req: no REF is granted, and other classes proceed normally.
// TESTING
//  1. Reset: hold rst_n=0 -> all gnt=0, cs_n=1, cke=0; release -> cke=1 the next cycle, DFI deselect.
//  2. act_req=4'b1111, t_rrd=3 -> ACTs to banks 0,1,2,3 at cycles N, N+3, N+6, N+9;
//     DFI ACT with addr=ra[b] one cycle after each grant.
//  3. WR bank0 then RD bank1 pending, t_ccd=2, t_wtr=5 -> RD granted 5 cycles after the WR;
//     dfi_odt=1 only in the WR cycle.
//  4. rd_req=4'b0101 held continuously, t_ccd=1 -> grants alternate bank0, bank2 with no gaps
//     (round-robin fairness).
//  5. ref_req=4'b0111 -> no REF granted; then 4'b1111 -> ref_gnt=4'b1111 for one cycle and a REF on DFI,
//     even while act_req is pending.
//  6. Reset asserted the same cycle as a rd_gnt -> DFI shows deselect, no RD is issued, and counters are cleared.

Source files
------------

// File: rtl/dram_cmd_scheduler.sv
// Inter-bank DRAM command scheduler: arbitrates bank-controller requests under
// tRRD/tCCD/tWTR/tRTW and drives a registered DFI command bus.
module dram_cmd_scheduler #(
    parameter int NUM_BANKS  = 4,
    parameter int BA_WIDTH   = 2,
    parameter int RA_WIDTH   = 14,
    parameter int CA_WIDTH   = 10,
    parameter int ADDR_WIDTH = 14,
    parameter int CS_WIDTH   = 1,
    parameter int T_WIDTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BANKS-1:0]          act_req,
    input  logic [NUM_BANKS-1:0]          rd_req,
    input  logic [NUM_BANKS-1:0]          wr_req,
    input  logic [NUM_BANKS-1:0]          pre_req,
    input  logic [NUM_BANKS-1:0]          ref_req,
    input  logic [NUM_BANKS*RA_WIDTH-1:0] ra,
    input  logic [NUM_BANKS*CA_WIDTH-1:0] ca,
    output logic [NUM_BANKS-1:0]          act_gnt,
    output logic [NUM_BANKS-1:0]          rd_gnt,
    output logic [NUM_BANKS-1:0]          wr_gnt,
    output logic [NUM_BANKS-1:0]          pre_gnt,
    output logic [NUM_BANKS-1:0]          ref_gnt,
    input  logic [T_WIDTH-1:0]            t_rrd,
    input  logic [T_WIDTH-1:0]            t_ccd,
    input  logic [T_WIDTH-1:0]            t_wtr,
    input  logic [T_WIDTH-1:0]            t_rtw,
    output logic                          dfi_cke,
    output logic [CS_WIDTH-1:0]           dfi_cs_n,
    output logic                          dfi_ras_n,
    output logic                          dfi_cas_n,
    output logic                          dfi_we_n,
    output logic [BA_WIDTH-1:0]           dfi_ba,
    output logic [ADDR_WIDTH-1:0]         dfi_addr,
    output logic                          dfi_odt
);

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF
    } cmd_e;

    function automatic logic [T_WIDTH-1:0] sat_dec(input logic [T_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - T_WIDTH'(1);
    endfunction

    // Returns {found, bank}: first candidate at or after ptr, wrapping.
    function automatic logic [BA_WIDTH:0] rr_pick(
        input logic [NUM_BANKS-1:0] cand,
        input logic [BA_WIDTH-1:0]  ptr
    );
        logic [BA_WIDTH:0]   res;
        logic [BA_WIDTH-1:0] idx;
        res = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            idx = ptr + BA_WIDTH'(i);
            if (cand[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [T_WIDTH-1:0]    rrd_q, rrd_d, ccd_q, ccd_d;
    logic [T_WIDTH-1:0]    wtr_q, wtr_d, rtw_q, rtw_d;
    logic [BA_WIDTH-1:0]   rr_q, rr_d;
    logic                  cke_q;
    logic [CS_WIDTH-1:0]   cs_n_q, cs_n_d;
    logic                  ras_n_q, ras_n_d, cas_n_q, cas_n_d;
    logic                  we_n_q, we_n_d, odt_q, odt_d;
    logic [BA_WIDTH-1:0]   ba_q, ba_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [NUM_BANKS-1:0]  rd_e, wr_e, act_e, pre_e;
    logic [NUM_BANKS-1:0]  col_cand, act_cand, onehot;
    logic [BA_WIDTH:0]     col_pick, act_pick, pre_pick;
    logic                  rd_ok, wr_ok, act_ok;
    logic [BA_WIDTH-1:0]   sel;
    logic [ADDR_WIDTH-1:0] ra_x, ca_x;
    cmd_e                  cmd;

    // A bank raising several requests at once resolves as rd > wr > act > pre.
    assign rd_e  = rd_req;
    assign wr_e  = wr_req & ~rd_req;
    assign act_e = act_req & ~rd_req & ~wr_req;
    assign pre_e = pre_req & ~rd_req & ~wr_req & ~act_req;

    assign rd_ok  = (ccd_q == '0) && (wtr_q == '0);
    assign wr_ok  = (ccd_q == '0) && (rtw_q == '0);
    assign act_ok = (rrd_q == '0);

    assign col_cand = (rd_e & {NUM_BANKS{rd_ok}}) | (wr_e & {NUM_BANKS{wr_ok}});
    assign act_cand = act_e & {NUM_BANKS{act_ok}};

    assign col_pick = rr_pick(col_cand, rr_q);
    assign act_pick = rr_pick(act_cand, rr_q);
    assign pre_pick = rr_pick(pre_e, rr_q);

    always_comb begin
        cmd = CMD_NOP;
        sel = '0;
        if (!rst_n) begin
            cmd = CMD_NOP;
        end else if (&ref_req) begin
            cmd = CMD_REF;
        end else if (col_pick[BA_WIDTH]) begin
            sel = col_pick[BA_WIDTH-1:0];
            cmd = (rd_e[sel] && rd_ok) ? CMD_RD : CMD_WR;
        end else if (act_pick[BA_WIDTH]) begin
            sel = act_pick[BA_WIDTH-1:0];
            cmd = CMD_ACT;
        end else if (pre_pick[BA_WIDTH]) begin
            sel = pre_pick[BA_WIDTH-1:0];
            cmd = CMD_PRE;
        end
    end

    assign onehot  = {{(NUM_BANKS-1){1'b0}}, 1'b1} << sel;
    assign act_gnt = (cmd == CMD_ACT) ? onehot : '0;
    assign rd_gnt  = (cmd == CMD_RD)  ? onehot : '0;
    assign wr_gnt  = (cmd == CMD_WR)  ? onehot : '0;
    assign pre_gnt = (cmd == CMD_PRE) ? onehot : '0;
    assign ref_gnt = {NUM_BANKS{cmd == CMD_REF}};

    always_comb begin
        rrd_d = (cmd == CMD_ACT) ? sat_dec(t_rrd) : sat_dec(rrd_q);
        ccd_d = (cmd == CMD_RD || cmd == CMD_WR) ? sat_dec(t_ccd) : sat_dec(ccd_q);
        wtr_d = (cmd == CMD_WR) ? sat_dec(t_wtr) : sat_dec(wtr_q);
        rtw_d = (cmd == CMD_RD) ? sat_dec(t_rtw) : sat_dec(rtw_q);
        rr_d  = (cmd == CMD_NOP || cmd == CMD_REF) ? rr_q : sel + BA_WIDTH'(1);
    end

    always_comb begin
        ra_x     = ADDR_WIDTH'(ra[int'(sel)*RA_WIDTH +: RA_WIDTH]);
        ca_x     = ADDR_WIDTH'(ca[int'(sel)*CA_WIDTH +: CA_WIDTH]);
        ca_x[10] = 1'b0;
        cs_n_d   = '1;
        ras_n_d  = 1'b1;
        cas_n_d  = 1'b1;
        we_n_d   = 1'b1;
        ba_d     = '0;
        addr_d   = '0;
        odt_d    = 1'b0;
        unique case (cmd)
            CMD_ACT: begin
                cs_n_d = '0; ras_n_d = 1'b0; ba_d = sel; addr_d = ra_x;
            end
            CMD_RD: begin
                cs_n_d = '0; cas_n_d = 1'b0; ba_d = sel; addr_d = ca_x;
            end
            CMD_WR: begin
                cs_n_d = '0; cas_n_d = 1'b0; we_n_d = 1'b0;
                ba_d = sel; addr_d = ca_x; odt_d = 1'b1;
            end
            CMD_PRE: begin
                cs_n_d = '0; ras_n_d = 1'b0; we_n_d = 1'b0; ba_d = sel;
            end
            CMD_REF: begin
                cs_n_d = '0; ras_n_d = 1'b0; cas_n_d = 1'b0;
            end
            default: begin
                cs_n_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_q   <= '0;
            ccd_q   <= '0;
            wtr_q   <= '0;
            rtw_q   <= '0;
            rr_q    <= '0;
            cke_q   <= 1'b0;
            cs_n_q  <= '1;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            ba_q    <= '0;
            addr_q  <= '0;
            odt_q   <= 1'b0;
        end else begin
            rrd_q   <= rrd_d;
            ccd_q   <= ccd_d;
            wtr_q   <= wtr_d;
            rtw_q   <= rtw_d;
            rr_q    <= rr_d;
            cke_q   <= 1'b1;
            cs_n_q  <= cs_n_d;
            ras_n_q <= ras_n_d;
            cas_n_q <= cas_n_d;
            we_n_q  <= we_n_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            odt_q   <= odt_d;
        end
    end

    assign dfi_cke   = cke_q;
    assign dfi_cs_n  = cs_n_q;
    assign dfi_ras_n = ras_n_q;
    assign dfi_cas_n = cas_n_q;
    assign dfi_we_n  = we_n_q;
    assign dfi_ba    = ba_q;
    assign dfi_addr  = addr_q;
    assign dfi_odt   = odt_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: directed scenarios plus a randomized run
// against a cycle-stamp reference model of the inter-bank timing rules.
module tb_dram_cmd_scheduler;

    localparam int NB  = 4;
    localparam int RAW = 14;
    localparam int CAW = 10;
    localparam int AW  = 14;

    localparam int K_NONE = 0;
    localparam int K_ACT  = 1;
    localparam int K_RD   = 2;
    localparam int K_WR   = 3;
    localparam int K_PRE  = 4;
    localparam int K_REF  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NB-1:0]   act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB*RAW-1:0] ra;
    logic [NB*CAW-1:0] ca;
    logic [NB-1:0]   act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [3:0]      t_rrd, t_ccd, t_wtr, t_rtw;
    logic            dfi_cke;
    logic [0:0]      dfi_cs_n;
    logic            dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [1:0]      dfi_ba;
    logic [AW-1:0]   dfi_addr;
    logic            dfi_odt;

    int total = 0;
    int bad   = 0;

    // model state: cycle stamps of the last grant per class
    int cyc, l_act, l_cas, l_wr, l_rd, rr;

    logic [20:0] dfi_obs;
    assign dfi_obs = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
                      dfi_ba, dfi_addr, dfi_odt};

    dram_cmd_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
        .pre_req(pre_req), .ref_req(ref_req),
        .ra(ra), .ca(ca),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .t_rrd(t_rrd), .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw),
        .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n),
        .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba),
        .dfi_addr(dfi_addr), .dfi_odt(dfi_odt)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            for (int b = 0; b < NB; b++) begin
                assert ($countones({act_req[b], rd_req[b], wr_req[b], pre_req[b]}) <= 1)
                else $error("illegal multi-request on bank %0d", b);
            end
        end
    end

    // {cs_n, ras_n, cas_n, we_n, ba, addr, odt} expected for a command
    function automatic logic [20:0] exp_dfi(input int k, input int b);
        logic [AW-1:0] r, c;
        logic [1:0]    bb;
        r  = AW'(ra[b*RAW +: RAW]);
        c  = AW'(ca[b*CAW +: CAW]);
        c[10] = 1'b0;
        bb = 2'(b);
        case (k)
            K_ACT:   return {4'b0011, bb, r, 1'b0};
            K_RD:    return {4'b0101, bb, c, 1'b0};
            K_WR:    return {4'b0100, bb, c, 1'b1};
            K_PRE:   return {4'b0010, bb, 14'd0, 1'b0};
            K_REF:   return {4'b0001, 2'b00, 14'd0, 1'b0};
            default: return {4'b1111, 2'b00, 14'd0, 1'b0};
        endcase
    endfunction

    // PRE only defines A10 of the address
    function automatic logic [20:0] exp_mask(input int k);
        logic [20:0] m;
        m = '1;
        if (k == K_PRE) begin
            m[14:1]  = '0;
            m[11]    = 1'b1;
        end
        return m;
    endfunction

    function automatic int mx1(input logic [3:0] t);
        return (t == 0) ? 1 : int'(t);
    endfunction

    function automatic void model_pick(output int k, output int b);
        bit rdok, wrok, actok;
        int bb;
        rdok  = (cyc - l_cas >= mx1(t_ccd)) && (cyc - l_wr >= mx1(t_wtr));
        wrok  = (cyc - l_cas >= mx1(t_ccd)) && (cyc - l_rd >= mx1(t_rtw));
        actok = (cyc - l_act >= mx1(t_rrd));
        k = K_NONE;
        b = 0;
        if (ref_req == 4'hF) begin
            k = K_REF;
            return;
        end
        for (int i = 0; i < NB; i++) begin
            bb = (rr + i) % NB;
            if (rd_req[bb] && rdok) begin k = K_RD; b = bb; return; end
            if (wr_req[bb] && wrok) begin k = K_WR; b = bb; return; end
        end
        for (int i = 0; i < NB; i++) begin
            bb = (rr + i) % NB;
            if (act_req[bb] && actok) begin k = K_ACT; b = bb; return; end
        end
        for (int i = 0; i < NB; i++) begin
            bb = (rr + i) % NB;
            if (pre_req[bb]) begin k = K_PRE; b = bb; return; end
        end
    endfunction

    task automatic clear_reqs();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    endtask

    // ends at posedge+1 with cke already high
    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        act_req = 4'hF;
        ref_req = 4'hF;
        #2;
        total++;
        if ({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} !== 20'h0) begin
            bad++;
            $display("FAIL reset_gnt got=%h want=0",
                     {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dfi_cke, dfi_obs} !== {1'b0, exp_dfi(K_NONE, 0)}) begin
            bad++;
            $display("FAIL reset_dfi got=%h want=%h", {dfi_cke, dfi_obs},
                     {1'b0, exp_dfi(K_NONE, 0)});
        end
        clear_reqs();
        rst_n = 1'b1;
        #1;
        total++;
        if (dfi_cke !== 1'b0) begin
            bad++;
            $display("FAIL cke_before_clk got=%b want=0", dfi_cke);
        end
        @(posedge clk);
        #1;
        total++;
        if ({dfi_cke, dfi_obs} !== {1'b1, exp_dfi(K_NONE, 0)}) begin
            bad++;
            $display("FAIL cke_rise got=%h want=%h", {dfi_cke, dfi_obs},
                     {1'b1, exp_dfi(K_NONE, 0)});
        end
    endtask

    task automatic test_act_rrd();
        int pb;
        logic [3:0] eg;
        t_rrd = 4'd3; t_ccd = 4'd0; t_wtr = 4'd0; t_rtw = 4'd0;
        ra = {$urandom, $urandom};
        do_reset();
        act_req = 4'hF;
        pb = -1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                total++;
                if (dfi_obs !== exp_dfi(pb >= 0 ? K_ACT : K_NONE, pb >= 0 ? pb : 0)) begin
                    bad++;
                    $display("FAIL act_dfi k=%0d got=%h want=%h", k, dfi_obs,
                             exp_dfi(pb >= 0 ? K_ACT : K_NONE, pb >= 0 ? pb : 0));
                end
            end
            if (pb >= 0) act_req[pb] = 1'b0;
            #1;
            eg = (k % 3 == 0 && k / 3 < 4) ? 4'(1 << (k / 3)) : 4'h0;
            total++;
            if (act_gnt !== eg) begin
                bad++;
                $display("FAIL act_rrd k=%0d got=%b want=%b", k, act_gnt, eg);
            end
            pb = (eg != 0) ? k / 3 : -1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wtr_odt();
        logic [7:0] eg;
        int ek;
        t_rrd = 4'd0; t_ccd = 4'd2; t_wtr = 4'd5; t_rtw = 4'd0;
        ca = {$urandom, $urandom};
        do_reset();
        wr_req = 4'b0001;
        rd_req = 4'b0010;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) begin
                ek = (k == 1) ? K_WR : (k == 6) ? K_RD : K_NONE;
                total++;
                if (dfi_obs !== exp_dfi(ek, ek == K_WR ? 0 : 1)) begin
                    bad++;
                    $display("FAIL wtr_dfi k=%0d got=%h want=%h", k, dfi_obs,
                             exp_dfi(ek, ek == K_WR ? 0 : 1));
                end
                total++;
                if (dfi_odt !== (k == 1)) begin
                    bad++;
                    $display("FAIL odt k=%0d got=%b want=%b", k, dfi_odt, k == 1);
                end
            end
            if (k == 1) wr_req = 4'b0;
            if (k == 6) rd_req = 4'b0;
            #1;
            eg = {(k == 0) ? 4'b0001 : 4'b0, (k == 5) ? 4'b0010 : 4'b0};
            total++;
            if ({wr_gnt, rd_gnt} !== eg) begin
                bad++;
                $display("FAIL wtr_gnt k=%0d got=%b want=%b", k, {wr_gnt, rd_gnt}, eg);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back_rr();
        t_rrd = 4'd0; t_ccd = 4'd1; t_wtr = 4'd0; t_rtw = 4'd0;
        do_reset();
        rd_req = 4'b0101;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                total++;
                if (dfi_obs !== exp_dfi(K_RD, ((k - 1) % 2 == 0) ? 0 : 2)) begin
                    bad++;
                    $display("FAIL rr_dfi k=%0d got=%h want=%h", k, dfi_obs,
                             exp_dfi(K_RD, ((k - 1) % 2 == 0) ? 0 : 2));
                end
            end
            #1;
            total++;
            if (rd_gnt !== ((k % 2 == 0) ? 4'b0001 : 4'b0100)) begin
                bad++;
                $display("FAIL rr_gnt k=%0d got=%b want=%b", k, rd_gnt,
                         (k % 2 == 0) ? 4'b0001 : 4'b0100);
            end
            @(posedge clk);
            #1;
        end
        rd_req = '0;
    endtask

    task automatic test_refresh();
        t_rrd = 4'd0; t_ccd = 4'd0; t_wtr = 4'd0; t_rtw = 4'd0;
        do_reset();
        ref_req = 4'b0111;
        act_req = 4'b1000;
        #1;
        total++;
        if ({ref_gnt, act_gnt} !== 8'b0000_1000) begin
            bad++;
            $display("FAIL ref_partial got=%b want=00001000", {ref_gnt, act_gnt});
        end
        @(posedge clk);
        #1;
        total++;
        if (dfi_obs !== exp_dfi(K_ACT, 3)) begin
            bad++;
            $display("FAIL ref_act3_dfi got=%h want=%h", dfi_obs, exp_dfi(K_ACT, 3));
        end
        act_req = 4'b0001;
        ref_req = 4'b1111;
        #1;
        total++;
        if ({ref_gnt, act_gnt} !== 8'b1111_0000) begin
            bad++;
            $display("FAIL ref_all got=%b want=11110000", {ref_gnt, act_gnt});
        end
        @(posedge clk);
        #1;
        total++;
        if (dfi_obs !== exp_dfi(K_REF, 0)) begin
            bad++;
            $display("FAIL ref_dfi got=%h want=%h", dfi_obs, exp_dfi(K_REF, 0));
        end
        ref_req = 4'b0;
        #1;
        total++;
        if ({ref_gnt, act_gnt} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL ref_after got=%b want=00000001", {ref_gnt, act_gnt});
        end
        @(posedge clk);
        #1;
        act_req = 4'b0;
        total++;
        if (dfi_obs !== exp_dfi(K_ACT, 0)) begin
            bad++;
            $display("FAIL ref_act0_dfi got=%h want=%h", dfi_obs, exp_dfi(K_ACT, 0));
        end
        @(posedge clk);
        #1;
        total++;
        if (dfi_obs !== exp_dfi(K_NONE, 0)) begin
            bad++;
            $display("FAIL ref_idle got=%h want=%h", dfi_obs, exp_dfi(K_NONE, 0));
        end
    endtask

    task automatic test_reset_mid();
        t_rrd = 4'd0; t_ccd = 4'd4; t_wtr = 4'd0; t_rtw = 4'd4;
        do_reset();
        rd_req = 4'b0001;
        #1;
        total++;
        if (rd_gnt !== 4'b0001) begin
            bad++;
            $display("FAIL mid_rd_gnt got=%b want=0001", rd_gnt);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} !== 20'h0) begin
            bad++;
            $display("FAIL mid_gnt_zero got=%h want=0",
                     {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt});
        end
        @(posedge clk);
        #1;
        total++;
        if ({dfi_cke, dfi_obs} !== {1'b0, exp_dfi(K_NONE, 0)}) begin
            bad++;
            $display("FAIL mid_no_rd got=%h want=%h", {dfi_cke, dfi_obs},
                     {1'b0, exp_dfi(K_NONE, 0)});
        end
        clear_reqs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 4'b0001;
        #1;
        total++;
        if (rd_gnt !== 4'b0001) begin
            bad++;
            $display("FAIL mid_rd2 got=%b want=0001", rd_gnt);
        end
        @(posedge clk);
        #1;
        rd_req = 4'b0;
        wr_req = 4'b0010;
        #1;
        total++;
        if (wr_gnt !== 4'b0000) begin
            bad++;
            $display("FAIL mid_rtw_block got=%b want=0000", wr_gnt);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        total++;
        if (wr_gnt !== 4'b0010) begin
            bad++;
            $display("FAIL mid_cnt_clear got=%b want=0010", wr_gnt);
        end
        @(posedge clk);
        #1;
        wr_req = 4'b0;
        total++;
        if (dfi_obs !== exp_dfi(K_WR, 1)) begin
            bad++;
            $display("FAIL mid_wr_dfi got=%h want=%h", dfi_obs, exp_dfi(K_WR, 1));
        end
    endtask

    task automatic test_random();
        int k, b, pk, pb, r;
        logic [19:0] eg;
        t_rrd = 4'($urandom_range(0, 4));
        t_ccd = 4'($urandom_range(0, 4));
        t_wtr = 4'($urandom_range(0, 5));
        t_rtw = 4'($urandom_range(0, 5));
        ra = {$urandom, $urandom};
        ca = {$urandom, $urandom};
        do_reset();
        cyc = 0; l_act = -100; l_cas = -100; l_wr = -100; l_rd = -100; rr = 0;
        pk = K_NONE; pb = 0;
        for (int n = 0; n < 400; n++) begin
            if (n > 0) begin
                total++;
                if ((dfi_obs & exp_mask(pk)) !== (exp_dfi(pk, pb) & exp_mask(pk))) begin
                    bad++;
                    $display("FAIL rand_dfi n=%0d got=%h want=%h", n, dfi_obs,
                             exp_dfi(pk, pb));
                end
            end
            clear_reqs();
            for (int i = 0; i < NB; i++) begin
                r = $urandom_range(0, 7);
                if (r == 0) act_req[i] = 1'b1;
                if (r == 1) rd_req[i]  = 1'b1;
                if (r == 2) wr_req[i]  = 1'b1;
                if (r == 3) pre_req[i] = 1'b1;
            end
            ref_req = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
            #1;
            model_pick(k, b);
            eg = '0;
            case (k)
                K_ACT: eg[19:16] = 4'(1 << b);
                K_RD:  eg[15:12] = 4'(1 << b);
                K_WR:  eg[11:8]  = 4'(1 << b);
                K_PRE: eg[7:4]   = 4'(1 << b);
                K_REF: eg[3:0]   = 4'hF;
                default: eg = '0;
            endcase
            total++;
            if ({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} !== eg) begin
                bad++;
                $display("FAIL rand_gnt n=%0d got=%h want=%h", n,
                         {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, eg);
            end
            @(posedge clk);
            if (k == K_ACT) l_act = cyc;
            if (k == K_RD) begin l_cas = cyc; l_rd = cyc; end
            if (k == K_WR) begin l_cas = cyc; l_wr = cyc; end
            if (k != K_NONE && k != K_REF) rr = (b + 1) % NB;
            cyc++;
            pk = k;
            pb = b;
            #1;
        end
        clear_reqs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        ra = '0; ca = '0;
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        test_reset();
        test_act_rrd();
        test_wtr_odt();
        test_back_to_back_rr();
        test_refresh();
        test_reset_mid();
        test_random();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
